// File: rtl/set_assoc_cache_pkg.sv
// Shared types and width helpers for the set-associative write-back cache.
// Default geometry lives here; the top derives its own widths from the same helpers.
package set_assoc_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVICT,
    S_FILL,
    S_DONE
  } state_e;

  localparam int DEF_WORD_SIZE  = 16;
  localparam int DEF_NUM_SETS   = 4;
  localparam int DEF_NUM_WAYS   = 2;
  localparam int DEF_LINE_WORDS = 4;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int word_size,
                               input int line_words,
                               input int num_sets);
    return word_size - off_w(line_words) - idx_w(num_sets);
  endfunction

  // A direct-mapped cache still carries a one-bit way index.
  function automatic int way_w(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

  localparam int OFF_BITS = off_w(DEF_LINE_WORDS);
  localparam int IDX_BITS = idx_w(DEF_NUM_SETS);
  localparam int TAG_BITS = tag_w(DEF_WORD_SIZE, DEF_LINE_WORDS,
                                  DEF_NUM_SETS);
  localparam int WAY_BITS = way_w(DEF_NUM_WAYS);

endpackage

// File: rtl/set_assoc_cache_way_victim_select.sv
// Replacement choice: first empty way wins, otherwise the set's
// round-robin pointer names the victim.
module way_victim_select
  import set_assoc_cache_pkg::*;
#(
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  parameter int WAY_W    = way_w(DEF_NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [WAY_W-1:0]    ptr_i,
  output logic [WAY_W-1:0]    way_o
);

  always_comb begin
    way_o = ptr_i;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) way_o = WAY_W'(w);
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate set-associative cache between a word-wide
// CPU port and a line-wide memory port, with hit/miss statistics.
module set_assoc_cache
  import set_assoc_cache_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int NUM_WAYS   = DEF_NUM_WAYS,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            readC,
  input  logic                            writeC,
  input  logic [WORD_SIZE-1:0]            address,
  input  logic [WORD_SIZE-1:0]            wdataC,
  output logic [WORD_SIZE-1:0]            rdataC,
  output logic                            readyC,
  output logic                            readM,
  output logic                            writeM,
  output logic [WORD_SIZE-1:0]            addressM,
  output logic [WORD_SIZE*LINE_WORDS-1:0] wdataM,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] rdataM,
  input  logic                            readyM,
  output logic [WORD_SIZE-1:0]            num_hit,
  output logic [WORD_SIZE-1:0]            num_miss
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(NUM_SETS);
  localparam int TAG_W  = tag_w(WORD_SIZE, LINE_WORDS, NUM_SETS);
  localparam int WAY_W  = way_w(NUM_WAYS);
  localparam int LINE_W = WORD_SIZE * LINE_WORDS;

  state_e               state_q;
  logic                 req_wr_q;
  logic                 first_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WAY_W-1:0]     victim_q;

  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]  dirty_q [NUM_SETS];
  logic [WAY_W-1:0]     rr_q    [NUM_SETS];
  logic [TAG_W-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]    line_q  [NUM_SETS][NUM_WAYS];

  logic [OFF_W-1:0]     off;
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [31:0]          off_lsb;

  assign {tag, idx, off} = addr_q;
  assign off_lsb = 32'(off) * 32'(WORD_SIZE);

  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic [LINE_W-1:0]    hit_line;
  logic [WORD_SIZE-1:0] hit_word;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_line = line_q[idx][hit_way];
  assign hit_word = hit_line[off_lsb +: WORD_SIZE];

  logic [WAY_W-1:0]     vsel;
  logic [TAG_W-1:0]     v_tag;
  logic [LINE_W-1:0]    v_line;
  logic                 v_dirty;
  logic [WORD_SIZE-1:0] fill_addr;
  logic [WAY_W-1:0]     rr_next;

  way_victim_select #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_victim (
    .valid_i (valid_q[idx]),
    .ptr_i   (rr_q[idx]),
    .way_o   (vsel)
  );

  assign v_tag     = tag_q[idx][vsel];
  assign v_line    = line_q[idx][vsel];
  assign v_dirty   = valid_q[idx][vsel] & dirty_q[idx][vsel];
  assign fill_addr = {tag, idx, {OFF_W{1'b0}}};
  assign rr_next   = (rr_q[idx] == WAY_W'(NUM_WAYS - 1)) ?
                     '0 : rr_q[idx] + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      req_wr_q <= 1'b0;
      first_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      victim_q <= '0;
      rdataC   <= '0;
      readyC   <= 1'b0;
      readM    <= 1'b0;
      writeM   <= 1'b0;
      addressM <= '0;
      wdataM   <= '0;
      num_hit  <= '0;
      num_miss <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (readC || writeC) begin
            addr_q   <= address;
            wdata_q  <= wdataC;
            req_wr_q <= writeC;
            first_q  <= 1'b1;
            state_q  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          first_q <= 1'b0;
          if (hit) begin
            if (first_q) num_hit <= num_hit + 1'b1;
            if (req_wr_q) dirty_q[idx][hit_way] <= 1'b1;
            else          rdataC <= hit_word;
            readyC  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            if (first_q) num_miss <= num_miss + 1'b1;
            victim_q <= vsel;
            if (v_dirty) begin
              writeM   <= 1'b1;
              addressM <= {v_tag, idx, {OFF_W{1'b0}}};
              wdataM   <= v_line;
              state_q  <= S_EVICT;
            end else begin
              readM    <= 1'b1;
              addressM <= fill_addr;
              state_q  <= S_FILL;
            end
          end
        end
        S_EVICT: begin
          if (readyM) begin
            dirty_q[idx][victim_q] <= 1'b0;
            writeM   <= 1'b0;
            readM    <= 1'b1;
            addressM <= fill_addr;
            state_q  <= S_FILL;
          end
        end
        S_FILL: begin
          if (readyM) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            rr_q[idx] <= rr_next;
            readM     <= 1'b0;
            state_q   <= S_LOOKUP;
          end
        end
        S_DONE: begin
          readyC  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          readyC  <= 1'b0;
          readM   <= 1'b0;
          writeM  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Line storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state_q == S_LOOKUP && hit && req_wr_q) begin
      line_q[idx][hit_way][off_lsb +: WORD_SIZE] <= wdata_q;
    end
    if (state_q == S_FILL && readyM) begin
      line_q[idx][victim_q] <= rdataM;
      tag_q[idx][victim_q]  <= tag;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench: directed vector table, reset corner cases and
// randomized traffic against a flat-memory reference model.
module tb_set_assoc_cache;

  localparam int NS = 4;
  localparam int NW = 2;

  logic        clk;
  logic        reset_n;
  logic        readC, writeC;
  logic [15:0] address, wdataC, rdataC;
  logic        readyC, readM, writeM, readyM;
  logic [15:0] addressM;
  logic [63:0] wdataM, rdataM;
  logic [15:0] num_hit, num_miss;

  set_assoc_cache dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .readC    (readC),
    .writeC   (writeC),
    .address  (address),
    .wdataC   (wdataC),
    .rdataC   (rdataC),
    .readyC   (readyC),
    .readM    (readM),
    .writeM   (writeM),
    .addressM (addressM),
    .wdataM   (wdataM),
    .rdataM   (rdataM),
    .readyM   (readyM),
    .num_hit  (num_hit),
    .num_miss (num_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Backing memory: untouched lines read as address ^ 0x3C3C per word.
  logic [63:0] mem [logic [15:0]];
  int          mem_delay = 1;
  logic [15:0] rd_log [$];
  logic [15:0] wr_log [$];
  logic [63:0] wl_log [$];

  function automatic logic [63:0] mem_get(input logic [15:0] la);
    logic [63:0] l;
    if (mem.exists(la)) return mem[la];
    for (int i = 0; i < 4; i++) l[i*16 +: 16] = (la + 16'(i)) ^ 16'h3C3C;
    return l;
  endfunction

  initial begin
    int cnt;
    readyM = 1'b0;
    rdataM = '0;
    cnt    = 0;
    forever begin
      @(negedge clk);
      readyM = 1'b0;
      if (!reset_n || !(readM || writeM)) cnt = 0;
      else begin
        cnt++;
        if (cnt >= mem_delay) begin
          if (writeM) begin
            mem[addressM] = wdataM;
            wr_log.push_back(addressM);
            wl_log.push_back(wdataM);
          end else begin
            rdataM = mem_get(addressM);
            rd_log.push_back(addressM);
          end
          readyM = 1'b1;
          cnt    = 0;
        end
      end
    end
  end

  bit both_seen  = 0;
  bit rc_with_rm = 0;
  int readm_cyc  = 0;

  always @(negedge clk) begin
    if (readM && writeM) both_seen = 1;
    if (readM && readyC) rc_with_rm = 1;
    if (readM) readm_cyc++;
  end

  // Reference: CPU-visible words plus per-set tag/valid/dirty/pointer.
  logic [15:0] gold [logic [15:0]];
  bit          rv  [NS][NW];
  bit          rdt [NS][NW];
  logic [11:0] rt  [NS][NW];
  int          rr  [NS];
  int          ehit, emiss;

  function automatic logic [15:0] gold_rd(input logic [15:0] a);
    logic [63:0] l;
    if (gold.exists(a)) return gold[a];
    l = mem_get({a[15:2], 2'b00});
    return l[32'(a[1:0])*16 +: 16];
  endfunction

  function automatic logic [63:0] gold_line(input logic [15:0] la);
    logic [63:0] l;
    for (int i = 0; i < 4; i++) l[i*16 +: 16] = gold_rd(la + 16'(i));
    return l;
  endfunction

  task automatic model_reset();
    gold.delete();
    for (int s = 0; s < NS; s++) begin
      rr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        rv[s][w] = 0; rdt[s][w] = 0; rt[s][w] = '0;
      end
    end
    ehit  = 0;
    emiss = 0;
  endtask

  task automatic ref_access(input bit wr, input logic [15:0] a,
                            input logic [15:0] d, output bit hit,
                            output bit wb, output logic [15:0] wba,
                            output logic [63:0] wbl,
                            output logic [15:0] rd);
    int s, v;
    logic [11:0] tg;
    s   = int'(a[3:2]);
    tg  = a[15:4];
    hit = 0; wb = 0; wba = '0; wbl = '0; v = 0;
    rd  = gold_rd(a);
    for (int w = 0; w < NW; w++)
      if (rv[s][w] && rt[s][w] == tg) begin hit = 1; v = w; end
    if (hit) ehit++;
    else begin
      emiss++;
      v = rr[s];
      for (int w = NW - 1; w >= 0; w--) if (!rv[s][w]) v = w;
      if (rv[s][v] && rdt[s][v]) begin
        wb  = 1;
        wba = {rt[s][v], a[3:2], 2'b00};
        wbl = gold_line(wba);
      end
      rv[s][v] = 1; rdt[s][v] = 0; rt[s][v] = tg;
      rr[s] = (rr[s] + 1) % NW;
    end
    if (wr) begin rdt[s][v] = 1; gold[a] = d; end
  endtask

  task automatic cpu_req(input bit wr, input logic [15:0] a,
                         input logic [15:0] d, output logic [15:0] rd,
                         output int lat);
    @(negedge clk);
    readC = !wr; writeC = wr; address = a; wdataC = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!readyC && lat < 200);
    rd = rdataC;
    readC = 0; writeC = 0;
  endtask

  task automatic run_check(input string nm, input bit wr,
                           input logic [15:0] a, input logic [15:0] d);
    bit hit, wb;
    logic [15:0] wba, erd, rd;
    logic [63:0] wbl;
    int nr, nw, lat, elat;
    ref_access(wr, a, d, hit, wb, wba, wbl, erd);
    nr = rd_log.size(); nw = wr_log.size();
    cpu_req(wr, a, d, rd, lat);
    elat = hit ? 2 : (wb ? 3 + 2 * mem_delay : 3 + mem_delay);
    chk({nm, "_lat"}, 64'(lat), 64'(elat));
    if (!wr) chk({nm, "_rdata"}, 64'(rd), 64'(erd));
    chk({nm, "_hits"}, 64'(num_hit), 64'(16'(ehit)));
    chk({nm, "_miss"}, 64'(num_miss), 64'(16'(emiss)));
    chk({nm, "_nrd"}, 64'(rd_log.size() - nr), 64'(hit ? 0 : 1));
    if (!hit && rd_log.size() > nr)
      chk({nm, "_rdaddr"}, 64'(rd_log[rd_log.size()-1]),
          64'({a[15:2], 2'b00}));
    chk({nm, "_nwr"}, 64'(wr_log.size() - nw), 64'(wb ? 1 : 0));
    if (wb && wr_log.size() > nw) begin
      chk({nm, "_wbaddr"}, 64'(wr_log[wr_log.size()-1]), 64'(wba));
      chk({nm, "_wbline"}, wl_log[wl_log.size()-1], wbl);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] erd;
    int          elat;
    logic [15:0] erda;
    logic [15:0] ewba;
    logic [63:0] ewbl;
    int          ehits;
    int          emisses;
  } vec_t;

  vec_t vt [6];

  initial begin
    bit          h, wb;
    logic [15:0] wba, erd, rd, a, d;
    logic [63:0] wbl;
    int          nr, nw, lat, k;
    bit          wr;

    vt[0] = '{0, 16'h0010, 16'h0000, 16'h00D0, 4, 16'h0010, 16'hFFFF,
              64'h0, 0, 1};
    vt[1] = '{0, 16'h0011, 16'h0000, 16'h00D1, 2, 16'hFFFF, 16'hFFFF,
              64'h0, 1, 1};
    vt[2] = '{1, 16'h0012, 16'hBEEF, 16'h0000, 2, 16'hFFFF, 16'hFFFF,
              64'h0, 2, 1};
    vt[3] = '{0, 16'h0050, 16'h0000, 16'h3C6C, 4, 16'h0050, 16'hFFFF,
              64'h0, 2, 2};
    vt[4] = '{0, 16'h0090, 16'h0000, 16'h3CAC, 5, 16'h0090, 16'h0010,
              64'h00D3_BEEF_00D1_00D0, 2, 3};
    vt[5] = '{0, 16'h0012, 16'h0000, 16'hBEEF, 4, 16'h0010, 16'hFFFF,
              64'h0, 2, 4};

    mem[16'h0010] = 64'h00D3_00D2_00D1_00D0;
    readC = 0; writeC = 0; address = '0; wdataC = '0;
    reset_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_readyC", 64'(readyC), 64'(0));
    chk("rst_readM", 64'(readM), 64'(0));
    chk("rst_writeM", 64'(writeM), 64'(0));
    chk("rst_rdataC", 64'(rdataC), 64'(0));
    chk("rst_addressM", 64'(addressM), 64'(0));
    chk("rst_wdataM", wdataM, 64'(0));
    chk("rst_num_hit", 64'(num_hit), 64'(0));
    chk("rst_num_miss", 64'(num_miss), 64'(0));
    reset_n = 1;

    mem_delay = 1;
    for (int i = 0; i < 6; i++) begin
      ref_access(vt[i].wr, vt[i].addr, vt[i].wd, h, wb, wba, wbl, erd);
      nr = rd_log.size(); nw = wr_log.size();
      cpu_req(vt[i].wr, vt[i].addr, vt[i].wd, rd, lat);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].elat));
      if (!vt[i].wr)
        chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vt[i].erd));
      chk($sformatf("vec%0d_hits", i), 64'(num_hit),
          64'(16'(vt[i].ehits)));
      chk($sformatf("vec%0d_miss", i), 64'(num_miss),
          64'(16'(vt[i].emisses)));
      chk($sformatf("vec%0d_nrd", i), 64'(rd_log.size() - nr),
          64'((vt[i].erda == 16'hFFFF) ? 0 : 1));
      if (vt[i].erda != 16'hFFFF && rd_log.size() > nr)
        chk($sformatf("vec%0d_rdaddr", i),
            64'(rd_log[rd_log.size()-1]), 64'(vt[i].erda));
      chk($sformatf("vec%0d_nwr", i), 64'(wr_log.size() - nw),
          64'((vt[i].ewba == 16'hFFFF) ? 0 : 1));
      if (vt[i].ewba != 16'hFFFF && wr_log.size() > nw) begin
        chk($sformatf("vec%0d_wbaddr", i),
            64'(wr_log[wr_log.size()-1]), 64'(vt[i].ewba));
        chk($sformatf("vec%0d_wbline", i), wl_log[wl_log.size()-1],
            vt[i].ewbl);
      end
    end

    // Slow memory: readM held for the whole wait, no early readyC.
    mem_delay  = 5;
    readm_cyc  = 0;
    rc_with_rm = 0;
    run_check("slow_mem", 0, 16'h0110, 16'h0000);
    chk("slow_readM_cycles", 64'(readm_cyc), 64'(5));
    chk("slow_readyC_during_readM", 64'(rc_with_rm), 64'(0));

    // Reset in the middle of a fill abandons it.
    mem_delay = 20;
    @(negedge clk);
    readC = 1; address = 16'h0210;
    k = 0;
    while (!readM && k < 50) begin @(negedge clk); k++; end
    chk("midfill_readM_up", 64'(readM), 64'(1));
    repeat (2) @(negedge clk);
    #1 reset_n = 0;
    #1;
    chk("midfill_readM_rst", 64'(readM), 64'(0));
    chk("midfill_addrM_rst", 64'(addressM), 64'(0));
    chk("midfill_miss_rst", 64'(num_miss), 64'(0));
    readC = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    model_reset();
    mem_delay = 1;
    run_check("post_rst", 0, 16'h0010, 16'h0000);

    for (int i = 0; i < 300; i++) begin
      wr = ($urandom_range(0, 9) < 4);
      a  = {12'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3))};
      d  = 16'($urandom);
      mem_delay = $urandom_range(1, 4);
      run_check($sformatf("rnd%0d", i), wr, a, d);
    end

    chk("readM_writeM_overlap", 64'(both_seen), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
